// File: rtl/noc_dmem_txn_ctrl.sv
// ---------------------------------------------------------------------------
// noc_dmem_txn_ctrl
//   Data-memory transaction controller for one core in a small NoC.
//   Each LSU request goes either to the local memory (the target node field
//   of the address equals NODE_ID) or to a remote node as a tagged packet.
//   At most one transaction is outstanding at any time.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   lsu2dmem_* / dmem2lsu_* LSU-side SCR1 dmem request / response
//   loc_*                   local memory SCR1 dmem request / response
//   tx_*                    network request packet (valid/ready)
//   rx_*                    network reply packet (valid/ready)
//   busy_o                  transaction in progress
//   timeout_o               one-cycle pulse, remote reply timed out
//   stale_drop_o            one-cycle pulse, an rx beat was discarded
// ---------------------------------------------------------------------------
package noc_dmem_pkg;
  localparam int unsigned SCR1_DMEM_AWIDTH = 32;
  localparam int unsigned SCR1_DMEM_DWIDTH = 32;

  localparam logic       SCR1_MEM_CMD_RD      = 1'b0;
  localparam logic       SCR1_MEM_CMD_WR      = 1'b1;
  localparam logic [1:0] SCR1_MEM_RESP_NOTRDY = 2'b00;
  localparam logic [1:0] SCR1_MEM_RESP_RDY_OK = 2'b01;
  localparam logic [1:0] SCR1_MEM_RESP_RDY_ER = 2'b10;
endpackage

module noc_dmem_txn_ctrl
  import noc_dmem_pkg::*;
#(
  parameter int NODE_ID         = 0,
  parameter int NODE_COUNT      = 9,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int NODE_FIELD_LSB  = 28,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // LSU side
  input  logic                          lsu2dmem_req_i,
  input  logic                          lsu2dmem_cmd_i,
  input  logic [1:0]                    lsu2dmem_width_i,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   lsu2dmem_addr_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   lsu2dmem_wdata_i,
  output logic                          dmem2lsu_req_ack_o,
  output logic [SCR1_DMEM_DWIDTH-1:0]   dmem2lsu_rdata_o,
  output logic [1:0]                    dmem2lsu_resp_o,
  // local memory
  output logic                          loc_req_o,
  output logic                          loc_cmd_o,
  output logic [1:0]                    loc_width_o,
  output logic [SCR1_DMEM_AWIDTH-1:0]   loc_addr_o,
  output logic [SCR1_DMEM_DWIDTH-1:0]   loc_wdata_o,
  input  logic                          loc_req_ack_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   loc_rdata_i,
  input  logic [1:0]                    loc_resp_i,
  // network TX
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [3:0]                    tx_dest_o,
  output logic [PACKET_ID_WIDTH-1:0]    tx_pkt_id_o,
  output logic                          tx_cmd_o,
  output logic [1:0]                    tx_width_o,
  output logic [SCR1_DMEM_AWIDTH-1:0]   tx_addr_o,
  output logic [SCR1_DMEM_DWIDTH-1:0]   tx_wdata_o,
  // network RX
  input  logic                          rx_valid_i,
  output logic                          rx_ready_o,
  input  logic [PACKET_ID_WIDTH-1:0]    rx_pkt_id_i,
  input  logic                          rx_err_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   rx_rdata_i,
  // status
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic                          stale_drop_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCAL_WAIT,
    ST_NET_SEND,
    ST_NET_WAIT,
    ST_RESP
  } state_t;

  state_t                        r_state;
  logic [PACKET_ID_WIDTH-1:0]    r_tag;
  logic [PACKET_ID_WIDTH-1:0]    r_pkt_id;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_cmd;
  logic [1:0]                    r_width;
  logic [SCR1_DMEM_AWIDTH-1:0]   r_addr;
  logic [SCR1_DMEM_DWIDTH-1:0]   r_wdata;
  logic [3:0]                    r_dest;
  logic [SCR1_DMEM_DWIDTH-1:0]   r_rdata;
  logic                          r_err;
  logic                          r_timeout;
  logic                          r_stale;

  logic [3:0] w_target;
  logic       w_local;
  logic       w_node_ok;
  logic       w_idle_req;
  logic       w_rx_match;
  logic       w_rx_stale;
  logic       w_cnt_done;

  assign w_target   = lsu2dmem_addr_i[NODE_FIELD_LSB +: 4];
  assign w_local    = (w_target == 4'(NODE_ID));
  assign w_node_ok  = (32'(w_target) < 32'(NODE_COUNT));
  assign w_idle_req = (r_state == ST_IDLE) && lsu2dmem_req_i;
  assign w_rx_match = rx_valid_i && (r_state == ST_NET_WAIT) && (rx_pkt_id_i == r_pkt_id);
  assign w_rx_stale = rx_valid_i && !w_rx_match;
  // Counter holds the number of NET_WAIT cycles already completed, so the
  // last permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
  assign w_cnt_done = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // The reply channel is always accepting except while held in reset.
  assign rx_ready_o   = rst_n;
  assign busy_o       = (r_state != ST_IDLE);
  assign timeout_o    = r_timeout;
  assign stale_drop_o = r_stale;

  assign tx_valid_o  = (r_state == ST_NET_SEND);
  assign tx_dest_o   = r_dest;
  assign tx_pkt_id_o = r_pkt_id;
  assign tx_cmd_o    = r_cmd;
  assign tx_width_o  = r_width;
  assign tx_addr_o   = r_addr;
  assign tx_wdata_o  = r_wdata;

  assign loc_req_o   = w_idle_req && w_local;
  assign loc_cmd_o   = lsu2dmem_cmd_i;
  assign loc_width_o = lsu2dmem_width_i;
  assign loc_addr_o  = lsu2dmem_addr_i;
  assign loc_wdata_o = lsu2dmem_wdata_i;

  always_comb begin
    dmem2lsu_req_ack_o = 1'b0;
    dmem2lsu_resp_o    = SCR1_MEM_RESP_NOTRDY;
    dmem2lsu_rdata_o   = '0;
    if (w_idle_req) begin
      dmem2lsu_req_ack_o = w_local ? loc_req_ack_i : 1'b1;
    end
    case (r_state)
      ST_LOCAL_WAIT: begin
        dmem2lsu_resp_o  = loc_resp_i;
        dmem2lsu_rdata_o = loc_rdata_i;
      end
      ST_RESP: begin
        dmem2lsu_resp_o  = r_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        dmem2lsu_rdata_o = r_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tag     <= '0;
      r_pkt_id  <= '0;
      r_cnt     <= '0;
      r_cmd     <= 1'b0;
      r_width   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_dest    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_stale   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      r_stale   <= w_rx_stale;
      case (r_state)
        ST_IDLE: begin
          if (lsu2dmem_req_i) begin
            if (w_local) begin
              if (loc_req_ack_i) r_state <= ST_LOCAL_WAIT;
            end else if (w_node_ok) begin
              r_cmd    <= lsu2dmem_cmd_i;
              r_width  <= lsu2dmem_width_i;
              r_addr   <= lsu2dmem_addr_i;
              r_wdata  <= lsu2dmem_wdata_i;
              r_dest   <= w_target;
              r_pkt_id <= r_tag;
              r_state  <= ST_NET_SEND;
            end else begin
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= ST_RESP;
            end
          end
        end
        ST_LOCAL_WAIT: begin
          if (loc_resp_i != SCR1_MEM_RESP_NOTRDY) r_state <= ST_IDLE;
        end
        ST_NET_SEND: begin
          if (tx_ready_i) begin
            r_tag   <= r_tag + 1'b1;
            r_cnt   <= '0;
            r_state <= ST_NET_WAIT;
          end
        end
        ST_NET_WAIT: begin
          // A matching reply takes priority over an expiring timeout.
          if (w_rx_match) begin
            r_err   <= rx_err_i;
            r_rdata <= ((r_cmd == SCR1_MEM_CMD_RD) && !rx_err_i) ? rx_rdata_i : '0;
            r_state <= ST_RESP;
          end else if (w_cnt_done) begin
            r_timeout <= 1'b1;
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_dmem_txn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_noc_dmem_txn_ctrl
//   Self-checking bench for noc_dmem_txn_ctrl (NODE_ID=2, NODE_COUNT=9,
//   TIMEOUT_CYCLES=8). A transaction-level model tracks the next packet tag
//   and derives the expected response of each transaction from its class
//   (local / remote / bad node), reply timing and error flag.
// ---------------------------------------------------------------------------
module tb_noc_dmem_txn_ctrl;

  localparam int PW   = 5;
  localparam int TOUT = 8;
  localparam int NID  = 2;
  localparam int NCNT = 9;

  localparam logic [1:0] R_NOTRDY = 2'b00;
  localparam logic [1:0] R_OK     = 2'b01;
  localparam logic [1:0] R_ER     = 2'b10;
  localparam logic       C_RD     = 1'b0;
  localparam logic       C_WR     = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lsu2dmem_req_i;
  logic          lsu2dmem_cmd_i;
  logic [1:0]    lsu2dmem_width_i;
  logic [31:0]   lsu2dmem_addr_i;
  logic [31:0]   lsu2dmem_wdata_i;
  logic          dmem2lsu_req_ack_o;
  logic [31:0]   dmem2lsu_rdata_o;
  logic [1:0]    dmem2lsu_resp_o;
  logic          loc_req_o;
  logic          loc_cmd_o;
  logic [1:0]    loc_width_o;
  logic [31:0]   loc_addr_o;
  logic [31:0]   loc_wdata_o;
  logic          loc_req_ack_i;
  logic [31:0]   loc_rdata_i;
  logic [1:0]    loc_resp_i;
  logic          tx_valid_o;
  logic          tx_ready_i;
  logic [3:0]    tx_dest_o;
  logic [PW-1:0] tx_pkt_id_o;
  logic          tx_cmd_o;
  logic [1:0]    tx_width_o;
  logic [31:0]   tx_addr_o;
  logic [31:0]   tx_wdata_o;
  logic          rx_valid_i;
  logic          rx_ready_o;
  logic [PW-1:0] rx_pkt_id_i;
  logic          rx_err_i;
  logic [31:0]   rx_rdata_i;
  logic          busy_o;
  logic          timeout_o;
  logic          stale_drop_o;

  noc_dmem_txn_ctrl #(
    .NODE_ID         (NID),
    .NODE_COUNT      (NCNT),
    .PACKET_ID_WIDTH (PW),
    .NODE_FIELD_LSB  (28),
    .TIMEOUT_CYCLES  (TOUT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .lsu2dmem_req_i     (lsu2dmem_req_i),
    .lsu2dmem_cmd_i     (lsu2dmem_cmd_i),
    .lsu2dmem_width_i   (lsu2dmem_width_i),
    .lsu2dmem_addr_i    (lsu2dmem_addr_i),
    .lsu2dmem_wdata_i   (lsu2dmem_wdata_i),
    .dmem2lsu_req_ack_o (dmem2lsu_req_ack_o),
    .dmem2lsu_rdata_o   (dmem2lsu_rdata_o),
    .dmem2lsu_resp_o    (dmem2lsu_resp_o),
    .loc_req_o          (loc_req_o),
    .loc_cmd_o          (loc_cmd_o),
    .loc_width_o        (loc_width_o),
    .loc_addr_o         (loc_addr_o),
    .loc_wdata_o        (loc_wdata_o),
    .loc_req_ack_i      (loc_req_ack_i),
    .loc_rdata_i        (loc_rdata_i),
    .loc_resp_i         (loc_resp_i),
    .tx_valid_o         (tx_valid_o),
    .tx_ready_i         (tx_ready_i),
    .tx_dest_o          (tx_dest_o),
    .tx_pkt_id_o        (tx_pkt_id_o),
    .tx_cmd_o           (tx_cmd_o),
    .tx_width_o         (tx_width_o),
    .tx_addr_o          (tx_addr_o),
    .tx_wdata_o         (tx_wdata_o),
    .rx_valid_i         (rx_valid_i),
    .rx_ready_o         (rx_ready_o),
    .rx_pkt_id_i        (rx_pkt_id_i),
    .rx_err_i           (rx_err_i),
    .rx_rdata_i         (rx_rdata_i),
    .busy_o             (busy_o),
    .timeout_o          (timeout_o),
    .stale_drop_o       (stale_drop_o)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   tag_m    = 0;     // model: tag of the next packet to be sent
  logic exp_stale = 1'b0; // model: stale pulse expected this cycle
  logic nxt_stale = 1'b0; // a non-matching beat is being driven this cycle

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; all single-cycle stimulus returns to idle values.
  task automatic tick();
    @(posedge clk);
    #1;
    exp_stale      = nxt_stale;
    nxt_stale      = 1'b0;
    lsu2dmem_req_i = 1'b0;
    loc_req_ack_i  = 1'b0;
    loc_resp_i     = R_NOTRDY;
    tx_ready_i     = 1'b0;
    rx_valid_i     = 1'b0;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic cmd, input logic [31:0] wdata);
    lsu2dmem_req_i   = 1'b1;
    lsu2dmem_addr_i  = addr;
    lsu2dmem_cmd_i   = cmd;
    lsu2dmem_width_i = 2'($urandom_range(0, 2));
    lsu2dmem_wdata_i = wdata;
  endtask

  task automatic local_txn(input logic [31:0] addr, input logic cmd, input int ackdly,
                           input int respdly, input logic [1:0] resp, input logic [31:0] data);
    logic [31:0] wd;
    wd = $urandom;
    tick();
    for (int i = 0; i < ackdly; i++) begin
      drive_req(addr, cmd, wd);
      #1;
      check_eq("loc_req_wait", loc_req_o, 1);
      check_eq("loc_noack", dmem2lsu_req_ack_o, 0);
      tick();
    end
    drive_req(addr, cmd, wd);
    loc_req_ack_i = 1'b1;
    #1;
    check_eq("loc_req", loc_req_o, 1);
    check_eq("loc_addr", loc_addr_o, addr);
    check_eq("loc_cmd", loc_cmd_o, cmd);
    check_eq("loc_wdata", loc_wdata_o, wd);
    check_eq("loc_ack", dmem2lsu_req_ack_o, 1);
    check_eq("loc_no_tx", tx_valid_o, 0);
    tick();
    for (int i = 0; i < respdly; i++) begin
      drive_req(addr, cmd, wd);
      #1;
      check_eq("locw_resp", dmem2lsu_resp_o, R_NOTRDY);
      check_eq("locw_req0", loc_req_o, 0);
      check_eq("locw_noack", dmem2lsu_req_ack_o, 0);
      check_eq("locw_busy", busy_o, 1);
      tick();
    end
    loc_resp_i  = resp;
    loc_rdata_i = data;
    #1;
    check_eq("loc_resp", dmem2lsu_resp_o, resp);
    check_eq("loc_rdata", dmem2lsu_rdata_o, data);
    check_eq("loc_tx0", tx_valid_o, 0);
    tick();
    #1;
    check_eq("loc_done_busy", busy_o, 0);
    check_eq("loc_done_resp", dmem2lsu_resp_o, R_NOTRDY);
  endtask

  // reply_at: NET_WAIT cycle index (0..TOUT-1) of the matching reply, or -1
  // for no reply. stale_pct: chance of a wrong-tag beat in the other cycles.
  task automatic remote_txn(input logic [31:0] addr, input logic cmd, input int txdly,
                            input int reply_at, input int stale_pct, input logic err,
                            input logic [31:0] data);
    int          t;
    logic [31:0] wd;
    logic        replied;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rd;
    t       = tag_m;
    wd      = $urandom;
    replied = 1'b0;
    tick();
    drive_req(addr, cmd, wd);
    #1;
    check_eq("rem_ack", dmem2lsu_req_ack_o, 1);
    check_eq("rem_locreq0", loc_req_o, 0);
    check_eq("rem_tx0", tx_valid_o, 0);
    tick();
    for (int i = 0; i < txdly; i++) begin
      drive_req(addr ^ 32'h0000_0100, cmd, wd);
      #1;
      check_eq("send_valid", tx_valid_o, 1);
      check_eq("send_noack", dmem2lsu_req_ack_o, 0);
      check_eq("send_busy", busy_o, 1);
      tick();
    end
    tx_ready_i = 1'b1;
    #1;
    check_eq("tx_valid", tx_valid_o, 1);
    check_eq("tx_tag", tx_pkt_id_o, t);
    check_eq("tx_dest", tx_dest_o, addr[31:28]);
    check_eq("tx_addr", tx_addr_o, addr);
    check_eq("tx_cmd", tx_cmd_o, cmd);
    check_eq("tx_wdata", tx_wdata_o, wd);
    tag_m = (tag_m + 1) % (1 << PW);
    tick();
    for (int k = 0; k < TOUT && !replied; k++) begin
      #1;
      check_eq("wait_resp", dmem2lsu_resp_o, R_NOTRDY);
      check_eq("wait_busy", busy_o, 1);
      check_eq("wait_tx0", tx_valid_o, 0);
      check_eq("wait_tmo0", timeout_o, 0);
      check_eq("wait_stale", stale_drop_o, exp_stale);
      if (k == reply_at) begin
        rx_valid_i  = 1'b1;
        rx_pkt_id_i = PW'(t);
        rx_err_i    = err;
        rx_rdata_i  = data;
        replied     = 1'b1;
      end else if (int'($urandom_range(0, 99)) < stale_pct) begin
        rx_valid_i  = 1'b1;
        rx_pkt_id_i = PW'((t + 1 + int'($urandom_range(0, 30))) % (1 << PW));
        rx_err_i    = 1'($urandom);
        rx_rdata_i  = $urandom;
        nxt_stale   = 1'b1;
      end
      tick();
    end
    exp_resp = (!replied || err) ? R_ER : R_OK;
    exp_rd   = (replied && !err && cmd == C_RD) ? data : 32'h0;
    #1;
    check_eq("resp_code", dmem2lsu_resp_o, exp_resp);
    check_eq("resp_rdata", dmem2lsu_rdata_o, exp_rd);
    check_eq("resp_timeout", timeout_o, !replied);
    check_eq("resp_stale", stale_drop_o, exp_stale);
    check_eq("resp_busy", busy_o, 1);
    tick();
    #1;
    check_eq("done_busy", busy_o, 0);
    check_eq("done_resp", dmem2lsu_resp_o, R_NOTRDY);
    check_eq("done_tmo0", timeout_o, 0);
  endtask

  task automatic bad_txn(input logic [31:0] addr, input logic cmd);
    tick();
    drive_req(addr, cmd, $urandom);
    #1;
    check_eq("bad_ack", dmem2lsu_req_ack_o, 1);
    check_eq("bad_locreq0", loc_req_o, 0);
    tick();
    #1;
    check_eq("bad_resp", dmem2lsu_resp_o, R_ER);
    check_eq("bad_rdata", dmem2lsu_rdata_o, 0);
    check_eq("bad_tx0", tx_valid_o, 0);
    check_eq("bad_tmo0", timeout_o, 0);
    tick();
    #1;
    check_eq("bad_done_busy", busy_o, 0);
    check_eq("bad_done_tx0", tx_valid_o, 0);
  endtask

  function automatic logic [31:0] remote_addr();
    int n;
    n = int'($urandom_range(0, NCNT - 2));
    if (n >= NID) n++;
    return {4'(n), 28'($urandom)};
  endfunction

  task automatic random_txn();
    int   sel;
    logic cmd;
    sel = int'($urandom_range(0, 99));
    cmd = 1'($urandom);
    if (sel < 55) begin
      remote_txn(remote_addr(), cmd, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TOUT - 1)),
                 30, ($urandom_range(0, 4) == 0), $urandom);
    end else if (sel < 85) begin
      local_txn({4'(NID), 28'($urandom)}, cmd, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? R_ER : R_OK, $urandom);
    end else begin
      bad_txn({4'(NCNT + int'($urandom_range(0, 15 - NCNT))), 28'($urandom)}, cmd);
    end
  endtask

  initial begin
    int old_tag;
    rst_n            = 1'b0;
    lsu2dmem_req_i   = 1'b0;
    lsu2dmem_cmd_i   = 1'b0;
    lsu2dmem_width_i = 2'b10;
    lsu2dmem_addr_i  = '0;
    lsu2dmem_wdata_i = '0;
    loc_req_ack_i    = 1'b0;
    loc_rdata_i      = '0;
    loc_resp_i       = R_NOTRDY;
    tx_ready_i       = 1'b0;
    rx_valid_i       = 1'b0;
    rx_pkt_id_i      = '0;
    rx_err_i         = 1'b0;
    rx_rdata_i       = '0;
    #2;
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_tx", tx_valid_o, 0);
    check_eq("rst_locreq", loc_req_o, 0);
    check_eq("rst_ack", dmem2lsu_req_ack_o, 0);
    check_eq("rst_rdata", dmem2lsu_rdata_o, 0);
    check_eq("rst_resp", dmem2lsu_resp_o, R_NOTRDY);
    check_eq("rst_tmo", timeout_o, 0);
    check_eq("rst_stale", stale_drop_o, 0);
    check_eq("rst_rxrdy", rx_ready_o, 0);
    #21 rst_n = 1'b1;
    #1;
    check_eq("rxrdy_after_rst", rx_ready_o, 1);

    // Directed scenarios
    local_txn(32'h2000_0010, C_RD, 0, 0, R_OK, 32'h0000_CAFE);
    remote_txn(32'h5000_0004, C_RD, 3, 0, 0, 1'b0, 32'h0000_1234);
    remote_txn(32'h3000_0008, C_RD, 0, 2, 0, 1'b0, 32'h0000_5678);
    // write: one wrong-tag beat in the first wait cycle, the match next
    tick();
    drive_req(32'h6000_0000, C_WR, 32'hDEAD_BEEF);
    #1;
    check_eq("wr_ack", dmem2lsu_req_ack_o, 1);
    tick();
    tx_ready_i = 1'b1;
    #1;
    check_eq("wr_tag", tx_pkt_id_o, tag_m);
    tick();
    rx_valid_i  = 1'b1;
    rx_pkt_id_i = PW'(tag_m + 7);
    rx_err_i    = 1'b0;
    rx_rdata_i  = 32'hAAAA_5555;
    nxt_stale   = 1'b1;
    tick();
    #1;
    check_eq("wr_stale_pulse", stale_drop_o, 1);
    rx_valid_i  = 1'b1;
    rx_pkt_id_i = PW'(tag_m);
    rx_rdata_i  = 32'h1357_9BDF;
    tick();
    #1;
    check_eq("wr_stale_once", stale_drop_o, 0);
    check_eq("wr_resp", dmem2lsu_resp_o, R_OK);
    check_eq("wr_rdata0", dmem2lsu_rdata_o, 0);
    tag_m = (tag_m + 1) % (1 << PW);
    tick();
    #1;
    check_eq("wr_done", busy_o, 0);

    remote_txn(32'h1000_0000, C_RD, 1, -1, 0, 1'b0, 32'hFFFF_FFFF);
    remote_txn(32'h7000_0040, C_RD, 0, TOUT - 1, 0, 1'b0, 32'h0BAD_F00D);
    remote_txn(32'h8000_0000, C_RD, 0, 1, 0, 1'b1, 32'h1111_2222);
    bad_txn(32'hC000_0000, C_RD);

    // At least 32 packets in a row so the tag wraps through 31 -> 0
    for (int i = 0; i < 34; i++) begin
      remote_txn(remote_addr(), 1'($urandom), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), 25, 1'b0, $urandom);
    end
    for (int i = 0; i < 40; i++) random_txn();

    // Reset while a reply is outstanding
    tick();
    drive_req(32'h4000_0000, C_RD, 32'h0);
    tick();
    tx_ready_i = 1'b1;
    #1;
    check_eq("pre_rst_tag", tx_pkt_id_o, tag_m);
    old_tag = tag_m;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy_o, 0);
    check_eq("midrst_rxrdy", rx_ready_o, 0);
    check_eq("midrst_resp", dmem2lsu_resp_o, R_NOTRDY);
    check_eq("midrst_tx", tx_valid_o, 0);
    tag_m = 0;
    tick();
    exp_stale = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("postrst_rxrdy", rx_ready_o, 1);
    rx_valid_i  = 1'b1;
    rx_pkt_id_i = PW'(old_tag);
    rx_rdata_i  = 32'h9999_9999;
    nxt_stale   = 1'b1;
    tick();
    #1;
    check_eq("postrst_stale", stale_drop_o, 1);
    check_eq("postrst_busy", busy_o, 0);
    check_eq("postrst_resp", dmem2lsu_resp_o, R_NOTRDY);
    remote_txn(32'h5000_0000, C_RD, 0, 0, 0, 1'b0, 32'h0000_4242);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/noc_dmem_txn_ctrl.md
NOC_DMEM_TXN_CTRL -- requirements
Module: noc_dmem_txn_ctrl

Interface
REQ-001 SHALL have parameter NODE_ID, default 0, meaning the node number of this core.
REQ-002 SHALL have parameter NODE_COUNT, default 9, meaning the number of valid node numbers in the network.
REQ-003 SHALL have parameter PACKET_ID_WIDTH, default 5, meaning the transaction tag width.
REQ-004 SHALL have parameter NODE_FIELD_LSB, default 28, meaning the LSB of the 4-bit target-node field in the address (addr[LSB+3:LSB]).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the maximum number of NET_WAIT cycles.
REQ-006 SHALL have clk, input, 1, the only clock; rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have LSU side ports lsu2dmem_req_i/cmd_i/width_i/addr_i[`SCR1_DMEM_AWIDTH]/wdata_i[`SCR1_DMEM_DWIDTH] as inputs and dmem2lsu_req_ack_o/rdata_o[`SCR1_DMEM_DWIDTH]/resp_o as outputs, all using the SCR1 dmem protocol and types.
REQ-008 SHALL have local memory ports loc_req_o/cmd_o/width_o/addr_o/wdata_o as outputs and loc_req_ack_i/rdata_i/resp_i as inputs, with the same widths and types as the LSU side.
REQ-009 SHALL have network TX ports tx_valid_o (out, 1), tx_ready_i (in, 1), tx_dest_o (out, 4), tx_pkt_id_o (out, PACKET_ID_WIDTH), tx_cmd_o, tx_width_o, tx_addr_o, tx_wdata_o (out).
REQ-010 SHALL have network RX ports rx_valid_i (in, 1), rx_ready_o (out, 1), rx_pkt_id_i (in, PACKET_ID_WIDTH), rx_err_i (in, 1), rx_rdata_i (in, DWIDTH).
REQ-011 SHALL have status outputs busy_o (1), timeout_o (1, pulse) and stale_drop_o (1, pulse).

Function
REQ-012 SHALL implement FSM states IDLE, LOCAL_WAIT, NET_SEND, NET_WAIT, RESP, with one outstanding transaction at most.
REQ-013 The target node SHALL be addr_i[NODE_FIELD_LSB+3:NODE_FIELD_LSB]; the request is local iff target == NODE_ID.
REQ-014 IDLE, local req: SHALL pass loc_req_o = lsu2dmem_req_i and cmd/width/addr/wdata through combinationally, drive dmem2lsu_req_ack_o = loc_req_ack_i, and go to LOCAL_WAIT on ack.
REQ-015 LOCAL_WAIT: SHALL pass loc_resp_i/loc_rdata_i to the LSU; return to IDLE when loc_resp_i != SCR1_MEM_RESP_NOTRDY; hold loc_req_o at 0.
REQ-016 IDLE, remote req with target < NODE_COUNT: SHALL assert dmem2lsu_req_ack_o the same cycle, latch cmd/width/addr/wdata, target and the current tag, then go to NET_SEND.
REQ-017 IDLE, remote req with target >= NODE_COUNT: SHALL ack and go to RESP with error status; no packet is sent.
REQ-018 NET_SEND: SHALL hold tx_valid_o=1 with stable latched fields until tx_ready_i=1; that cycle, increment the tag (mod 2^PACKET_ID_WIDTH), clear the timeout counter and go to NET_WAIT.
REQ-019 NET_WAIT: each cycle increments the timeout counter; rx_valid_i with rx_pkt_id_i == latched tag SHALL latch rx_rdata_i and rx_err_i and go to RESP.
REQ-020 NET_WAIT: when the counter reaches TIMEOUT_CYCLES SHALL pulse timeout_o one cycle and go to RESP with error; a matching rx in the same cycle SHALL win (no timeout).
REQ-021 rx_ready_o SHALL be 1 in all states after reset; any rx beat that is not a tag match in NET_WAIT is discarded and pulses stale_drop_o one cycle.
REQ-022 RESP: SHALL drive dmem2lsu_resp_o = SCR1_MEM_RESP_RDY_OK (or RDY_ER on error/timeout/bad node) for exactly one cycle, then go to IDLE.
REQ-023 RESP rdata_o SHALL be the latched rx data for a successful read and 0 for writes and errors; requests are not acked in NET_SEND, NET_WAIT or RESP.
REQ-024 Outside LOCAL_WAIT/RESP, dmem2lsu_resp_o SHALL be SCR1_MEM_RESP_NOTRDY; busy_o = (state != IDLE).

Reset
REQ-025 On rst_n=0 SHALL enter IDLE with tag=0, timeout counter=0, tx_valid_o=0, loc_req_o=0, ack=0, rdata_o=0, resp_o=NOTRDY, timeout_o=0, stale_drop_o=0, and rx_ready_o=0 while reset is asserted.
REQ-026 Reset mid-transaction SHALL abandon it with no response; a later reply carrying the old tag is dropped as stale.

Verification
REQ-027 NODE_ID=2, read addr 0x2000_0010 -> loc_req_o mirrors the request; loc resp RDY_OK with 0xCAFE is seen on the LSU the same cycle; tx_valid_o stays 0.
REQ-028 Read addr 0x5000_0004, tx_ready_i delayed 3 cycles, rx tag 0 with data 0x1234 -> one RDY_OK with 0x1234; the next remote request uses tag 1.
REQ-029 Remote write, rx with a wrong tag and then the right tag -> one stale_drop_o pulse, then RDY_OK with rdata 0.
REQ-030 TIMEOUT_CYCLES=8, no reply -> timeout_o and RDY_ER exactly 8 cycles after the tx handshake; busy_o drops the next cycle.
REQ-031 Addr 0xC000_0000 (node 12 >= 9) -> ack, RDY_ER the next cycle, no tx.
REQ-032 32 remote transactions -> tag wraps 31 -> 0; rst_n pulsed during NET_WAIT -> IDLE with tag 0 and the stale reply dropped.
